// File: rtl/ts_stream_checker.sv
// ts_stream_checker: passive TS sync/length/TEI monitor with lock FSM, saturating stats and activity LED
module ts_stream_checker #(
   parameter int PKT_LEN    = 188,
   parameter int LOCK_CNT   = 3,
   parameter int UNLOCK_CNT = 3,
   parameter int CNT_W      = 16,
   parameter int LED_HOLD   = 2700000
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic [7:0]       data_i,
   input  logic             d_valid_i,
   input  logic             p_sync_i,
   input  logic             clr_cnt_i,
   output logic             locked_o,
   output logic             pkt_strobe_o,
   output logic             err_strobe_o,
   output logic             tei_strobe_o,
   output logic [CNT_W-1:0] good_cnt_o,
   output logic [CNT_W-1:0] err_cnt_o,
   output logic [CNT_W-1:0] tei_cnt_o,
   output logic             led_act_o
);
   localparam int IDX_W = $clog2(PKT_LEN);
   localparam int RUN_W = $clog2((LOCK_CNT > UNLOCK_CNT ? LOCK_CNT : UNLOCK_CNT) + 1);
   localparam int LED_W = $clog2(LED_HOLD + 1);
   typedef enum logic [1:0] {HUNT, IN_PKT, GAP, DISCARD} state_t;
   state_t           state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic             tei_q, tei_d;
   logic             good_ev, bad_ev, tei_ev, start;
   logic [RUN_W-1:0] good_run_q, good_run_d, bad_run_q, bad_run_d;
   logic             locked_q, locked_d;
   logic [CNT_W-1:0] good_cnt_q, good_cnt_d, err_cnt_q, err_cnt_d, tei_cnt_q, tei_cnt_d;
   logic [LED_W-1:0] led_q, led_d;
   logic             pkt_q, err_q, tei_s_q;
   assign start  = d_valid_i & p_sync_i & (data_i == 8'h47);
   assign tei_ev = good_ev & tei_q;
   // packet framing: track byte index, classify each accepted byte as good end, error or neither
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      tei_d   = tei_q;
      good_ev = 1'b0;
      bad_ev  = 1'b0;
      if (d_valid_i) begin
         case (state_q)
            IN_PKT: begin
               if (p_sync_i) begin
                  bad_ev  = 1'b1;
                  state_d = start ? IN_PKT : DISCARD;
                  idx_d   = start ? IDX_W'(1) : '0;
               end else if (idx_q == IDX_W'(PKT_LEN - 1)) begin
                  good_ev = 1'b1;
                  state_d = GAP;
                  idx_d   = '0;
               end else begin
                  idx_d = idx_q + IDX_W'(1);
                  tei_d = (idx_q == IDX_W'(1)) ? data_i[7] : tei_q;
               end
            end
            GAP: begin
               bad_ev  = ~start;
               state_d = start ? IN_PKT : DISCARD;
               idx_d   = start ? IDX_W'(1) : '0;
            end
            default: begin
               state_d = start ? IN_PKT : state_q;
               idx_d   = start ? IDX_W'(1) : idx_q;
            end
         endcase
      end
   end
   // lock hysteresis and saturating statistics; clear beats a coincident increment
   always_comb begin
      good_run_d = good_ev ? (good_run_q == RUN_W'(LOCK_CNT) ? good_run_q : good_run_q + RUN_W'(1)) :
                   bad_ev  ? '0 : good_run_q;
      bad_run_d  = bad_ev  ? (bad_run_q == RUN_W'(UNLOCK_CNT) ? bad_run_q : bad_run_q + RUN_W'(1)) :
                   good_ev ? '0 : bad_run_q;
      locked_d   = (good_ev && good_run_d == RUN_W'(LOCK_CNT))  ? 1'b1 :
                   (bad_ev  && bad_run_d == RUN_W'(UNLOCK_CNT)) ? 1'b0 : locked_q;
      good_cnt_d = clr_cnt_i ? '0 : (good_ev && good_cnt_q != '1) ? good_cnt_q + CNT_W'(1) : good_cnt_q;
      err_cnt_d  = clr_cnt_i ? '0 : (bad_ev  && err_cnt_q  != '1) ? err_cnt_q  + CNT_W'(1) : err_cnt_q;
      tei_cnt_d  = clr_cnt_i ? '0 : (tei_ev  && tei_cnt_q  != '1) ? tei_cnt_q  + CNT_W'(1) : tei_cnt_q;
      led_d      = good_ev ? LED_W'(LED_HOLD - 1) : (led_q != '0) ? led_q - LED_W'(1) : led_q;
   end
   // state and output registers
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= HUNT;
         idx_q      <= '0;
         tei_q      <= 1'b0;
         good_run_q <= '0;
         bad_run_q  <= '0;
         locked_q   <= 1'b0;
         good_cnt_q <= '0;
         err_cnt_q  <= '0;
         tei_cnt_q  <= '0;
         led_q      <= '0;
         pkt_q      <= 1'b0;
         err_q      <= 1'b0;
         tei_s_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         tei_q      <= tei_d;
         good_run_q <= good_run_d;
         bad_run_q  <= bad_run_d;
         locked_q   <= locked_d;
         good_cnt_q <= good_cnt_d;
         err_cnt_q  <= err_cnt_d;
         tei_cnt_q  <= tei_cnt_d;
         led_q      <= led_d;
         pkt_q      <= good_ev;
         err_q      <= bad_ev;
         tei_s_q    <= tei_ev;
      end
   end
   assign locked_o     = locked_q;
   assign pkt_strobe_o = pkt_q;
   assign err_strobe_o = err_q;
   assign tei_strobe_o = tei_s_q;
   assign good_cnt_o   = good_cnt_q;
   assign err_cnt_o    = err_cnt_q;
   assign tei_cnt_o    = tei_cnt_q;
   assign led_act_o    = (led_q != '0) | pkt_q;
endmodule
